// File: rtl/update_apply.sv
// update_apply: two-lane update consumer applying a combine op to an
// on-chip vertex property buffer through a 3-stage read-modify-write pipe.
module update_apply #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int SLACK      = 3,
  parameter int COMBINE_OP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InputValid_A,
  input  logic              InputValid_B,
  input  logic [DATA_W-1:0] InDestVid_A,
  input  logic [DATA_W-1:0] InDestVid_B,
  input  logic [DATA_W-1:0] InUpdate_A,
  input  logic [DATA_W-1:0] InUpdate_B,
  input  logic [DATA_W-1:0] IntervalBase,
  output logic              InReady,
  input  logic              HostEn,
  input  logic              HostWe,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [DATA_W-1:0] HostWrData,
  output logic [DATA_W-1:0] HostRdData,
  output logic              Idle,
  output logic [DATA_W-1:0] ChangeCount,
  input  logic              ClrCount,
  output logic              Overflow,
  output logic              RangeErr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] RDY_CNT =
    CNT_W'(FIFO_DEPTH - 2 * (SLACK + 1));

  typedef struct packed {
    logic [DATA_W-1:0] vid;
    logic [DATA_W-1:0] upd;
  } entry_t;

  entry_t            fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n, cnt_a;
  logic              push_a, push_b, pop;
  entry_t            head;
  logic [DATA_W-1:0] off;
  logic              in_range, s0_issue;
  logic [ADDR_W-1:0] s0_addr;

  logic              s1_v, s2_v, wb_v;
  logic [ADDR_W-1:0] s1_addr, s2_addr, wb_addr;
  logic [DATA_W-1:0] s1_upd, s2_upd, s2_old, wb_data;
  logic [DATA_W-1:0] s1_old, s2_new;
  logic              s2_we, s2_chg;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] ram_q, hold_q;
  logic              ram_we, host_ok, host_wr, host_rd, rd_q;
  logic [ADDR_W-1:0] ram_wa, ram_ra;
  logic [DATA_W-1:0] ram_wd;
  logic              idle_q;

  // Lane A claims the last free slot before lane B.
  always_comb begin
    push_a   = InputValid_A && (cnt_q != FULL_CNT);
    cnt_a    = cnt_q + CNT_W'(push_a);
    push_b   = InputValid_B && (cnt_a != FULL_CNT);
    pop      = (cnt_q != '0);
    head     = fifo_q[rd_ptr_q];
    off      = head.vid - IntervalBase;
    in_range = (off[DATA_W-1:ADDR_W] == '0);
    s0_issue = pop && in_range;
    s0_addr  = off[ADDR_W-1:0];
    wr_ptr_n = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
    cnt_n    = cnt_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
  end

  assign InReady = (cnt_q <= RDY_CNT);

  always_ff @(posedge clk) begin
    if (push_a) fifo_q[wr_ptr_q] <= '{vid: InDestVid_A, upd: InUpdate_A};
    if (push_b)
      fifo_q[wr_ptr_q + PTR_W'(push_a)] <=
        '{vid: InDestVid_B, upd: InUpdate_B};
  end

  // Newest in-flight value wins over older write and RAM data.
  always_comb begin
    s1_old = ram_q;
    if (wb_v && wb_addr == s1_addr) s1_old = wb_data;
    if (s2_v && s2_addr == s1_addr) s1_old = s2_new;
  end

  always_comb begin
    s2_new = s2_old;
    s2_we  = 1'b0;
    if (COMBINE_OP == 0) begin
      if (s2_upd < s2_old) s2_new = s2_upd;
      s2_we = s2_v && (s2_upd < s2_old);
    end else begin
      s2_new = s2_old + s2_upd;
      s2_we  = s2_v;
    end
    s2_chg = s2_v && (s2_new != s2_old);
  end

  always_comb begin
    host_ok = HostEn && idle_q && !InputValid_A && !InputValid_B;
    host_wr = host_ok && HostWe;
    host_rd = host_ok && !HostWe;
    ram_we  = (s2_we || host_wr) && !rst;
    ram_wa  = host_wr ? HostAddr : s2_addr;
    ram_wd  = host_wr ? HostWrData : s2_new;
    ram_ra  = host_rd ? HostAddr : s0_addr;
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_wa] <= ram_wd;
    ram_q <= mem_q[ram_ra];
  end

  assign HostRdData = rd_q ? ram_q : hold_q;
  assign Idle       = idle_q;

  always_ff @(posedge clk) begin
    s1_addr <= s0_addr;
    s1_upd  <= head.upd;
    s2_addr <= s1_addr;
    s2_upd  <= s1_upd;
    s2_old  <= s1_old;
    wb_addr <= s2_addr;
    wb_data <= s2_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      s1_v        <= 1'b0;
      s2_v        <= 1'b0;
      wb_v        <= 1'b0;
      ChangeCount <= '0;
      Overflow    <= 1'b0;
      RangeErr    <= 1'b0;
      idle_q      <= 1'b1;
      rd_q        <= 1'b0;
      hold_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      cnt_q    <= cnt_n;
      s1_v     <= s0_issue;
      s2_v     <= s1_v;
      wb_v     <= s2_we;
      if (ClrCount)    ChangeCount <= '0;
      else if (s2_chg) ChangeCount <= ChangeCount + 1'b1;
      if ((InputValid_A && !push_a) || (InputValid_B && !push_b))
        Overflow <= 1'b1;
      if (pop && !in_range) RangeErr <= 1'b1;
      idle_q <= (cnt_n == '0) && !s0_issue && !s1_v;
      rd_q   <= host_rd;
      hold_q <= HostRdData;
    end
  end

endmodule

// File: doc/update_apply.md
Name: update_apply

Overview:
- Consumer of the two-lane compare-and-combine update stream (valid, dest vid, update per lane).
- Serialises both lanes through an input FIFO and applies each update to an on-chip vertex-property buffer with a 3-stage read-modify-write pipeline.
- Provides hazard forwarding, backpressure to the upstream network, changed-vertex counting, and a host port for initialising and reading the buffer between phases.

Parameters:
- DATA_W, 32, width of vertex id, update and property values.
- ADDR_W, 10, vertex buffer address width; depth is 2^ADDR_W.
- FIFO_DEPTH, 16, input FIFO entries; power of two, >= 4*(SLACK+1).
- SLACK, 3, upstream pipeline depth that continues to deliver after InReady falls.
- COMBINE_OP, 0, 0 = unsigned min, 1 = add (wraps modulo 2^DATA_W).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- InputValid_A / InputValid_B  in  1  lane valid
- InDestVid_A / InDestVid_B  in  DATA_W  destination vertex id
- InUpdate_A / InUpdate_B  in  DATA_W  update value
- IntervalBase  in  DATA_W  first vid of the resident interval; must be stable while Idle=0
- InReady  out  1  upstream may present valid lanes
- HostEn  in  1  host access strobe
- HostWe  in  1  1 = write, 0 = read
- HostAddr  in  ADDR_W  buffer address
- HostWrData  in  DATA_W  write data
- HostRdData  out  DATA_W  read data, 1-cycle latency
- Idle  out  1  FIFO empty and pipeline empty
- ChangeCount  out  DATA_W  number of writes that changed a stored value
- ClrCount  in  1  clears ChangeCount
- Overflow  out  1  sticky: an entry was dropped because the FIFO was full
- RangeErr  out  1  sticky: a vid outside the interval was dropped

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset clears: FIFO empty, all stage valids 0, ChangeCount 0, Overflow 0, RangeErr 0, HostRdData 0.
  - After reset: InReady 1, Idle 1.
  - Buffer RAM contents are not reset.
- Enqueue (per cycle):
  - Lane A is written before lane B; both may be written in the same cycle.
  - A lane arriving while the FIFO is full is dropped and sets Overflow. Lane A takes the last free slot first.
- InReady = (occupancy <= FIFO_DEPTH - 2*(SLACK+1)), computed from the registered occupancy.
  - Guarantees no overflow while upstream stops issuing within SLACK cycles.
- S0, issue:
  - Pops one entry per cycle when the FIFO is non-empty.
  - off = vid - IntervalBase, unsigned DATA_W subtraction.
  - If off >= 2^ADDR_W, the entry is discarded, RangeErr is set, and a bubble goes down the pipe.
  - Otherwise, issues the RAM read at off[ADDR_W-1:0].
- S1, data:
  - RAM read data arrives (registered read, read-first).
  - Forwarding, most recent first: if the S2 entry is valid with the same address, use the S2 result; else if the write from the previous cycle hit the same address, use that value; else use RAM data.
- S2, combine/write:
  - min mode: new = min(old, upd); write only when upd < old.
  - add mode: new = old + upd; write always.
  - ChangeCount increments by 1 when new != old.
  - An entry popped in cycle t is written in cycle t+2.
  - Sustained throughput is 1 update/cycle; dual-lane input at full rate is limited by InReady.
- ClrCount: ChangeCount becomes 0 next cycle. If an increment happens in the same cycle, the increment is lost.
- Idle = FIFO empty and S0/S1/S2 all invalid; registered.
- Host port:
  - Honoured only when Idle=1 and no lane is valid that cycle; otherwise ignored (no write, HostRdData holds).
  - Write: RAM[HostAddr] = HostWrData.
  - Read: HostRdData is valid the next cycle.
- Reset asserted mid-operation: all in-flight and queued entries are discarded. A RAM write in the same cycle as rst is suppressed.

Test Plan:
1. Single min update: host writes addr 5 = 100, IntervalBase = 1000; lane A vid 1005, upd 40 -> write at pop+2, Idle returns, host read of addr 5 = 40, ChangeCount = 1.
2. Same-cycle duplicates: addr 7 = 50; A and B both vid base+7 with upd 30, 20 -> final 20, ChangeCount = 2. Repeat with B upd 60 -> final 30, ChangeCount = 1.
3. Back-to-back hazard: addr 3 = 100; vid base+3 upd 9, 8, 7 on consecutive cycles -> 7, ChangeCount = 3. Add mode with addr 3 = 0 and upd 1, 2, 3 -> 6, which checks both forwarding paths.
4. Backpressure (FIFO_DEPTH 16, SLACK 3): dual-lane stream honouring InReady with 3-cycle lag -> InReady low at occupancy > 8, Overflow stays 0, all 64 updates applied. Ignoring InReady -> Overflow = 1.
5. Range: ADDR_W 10, vid base+1024 and base-1 -> both dropped, RangeErr = 1, RAM unchanged, ChangeCount unchanged.
6. Reset mid-stream with 6 entries queued -> next cycle Idle = 1, InReady = 1, counters 0, no further RAM writes. Host write/read attempted while Idle = 0 is ignored.
